// File: rtl/sti_dac_pkg.sv
// rtl/sti_dac_pkg.sv - shared types, encodings and frame helpers for the STI/DAC unit
package sti_dac_pkg;

   localparam int NPIX  = 256;
   localparam int BANKS = 4;

   typedef enum logic [1:0] {
      LEN8  = 2'b00,
      LEN16 = 2'b01,
      LEN24 = 2'b10,
      LEN32 = 2'b11
   } len_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_FILL,
      S_DONE
   } state_e;

   function automatic logic [5:0] frame_bits(input logic [1:0] len);
      return {1'b0, len, 3'b000} + 6'd8;
   endfunction

   // Frame value right-aligned in 32 bits; only the low frame_bits() bits are sent.
   function automatic logic [31:0] build_frame(input logic [15:0] data,
                                               input logic [1:0]  len,
                                               input logic        fill,
                                               input logic        low);
      logic [31:0] f;
      f = '0;
      case (len)
         LEN8:    f = {24'h0, (low ? data[15:8] : data[7:0])};
         LEN16:   f = {16'h0, data};
         LEN24:   f = fill ? {8'h0, data, 8'h00} : {16'h0, data};
         default: f = fill ? {data, 16'h0000} : {16'h0, data};
      endcase
      return f;
   endfunction

endpackage

// File: rtl/sti_dac_oem_wr.sv
// rtl/sti_dac_oem_wr.sv - pixel index to odd/even bank decode and one-shot write strobes
module sti_dac_oem_wr
   import sti_dac_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_req,
   input  logic [7:0]       wr_pix,
   input  logic [7:0]       wr_data,
   output logic [4:0]       oem_addr,
   output logic [7:0]       oem_dataout,
   output logic [BANKS-1:0] odd_wr,
   output logic [BANKS-1:0] even_wr,
   output logic             busy,
   output logic             idle
);

   logic             pend;
   logic             to_odd;
   logic [1:0]       bank;
   logic [BANKS-1:0] bank_hot;

   assign bank_hot = BANKS'(1) << bank;
   assign busy     = pend;
   assign idle     = !pend && (odd_wr == '0) && (even_wr == '0);

   // Address/data land one cycle ahead of the strobe and hold until the next request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oem_addr    <= '0;
         oem_dataout <= '0;
         to_odd      <= 1'b0;
         bank        <= '0;
         pend        <= 1'b0;
         odd_wr      <= '0;
         even_wr     <= '0;
      end else begin
         if (wr_req) begin
            oem_addr    <= wr_pix[5:1];
            oem_dataout <= wr_data;
            to_odd      <= ~(wr_pix[4] ^ wr_pix[0]);
            bank        <= wr_pix[7:6];
         end
         pend    <= wr_req;
         odd_wr  <= (pend &&  to_odd) ? bank_hot : '0;
         even_wr <= (pend && !to_odd) ? bank_hot : '0;
      end
   end

endmodule

// File: rtl/sti_dac_unit.sv
// rtl/sti_dac_unit.sv - serial transmitter with pixel packing into odd/even image memories
module sti_dac_unit
   import sti_dac_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] pi_data,
   input  logic [1:0]  pi_length,
   input  logic        pi_fill,
   input  logic        pi_msb,
   input  logic        pi_low,
   input  logic        pi_end,
   output logic        so_data,
   output logic        so_valid,
   output logic [4:0]  oem_addr,
   output logic [7:0]  oem_dataout,
   output logic        odd1_wr,
   output logic        odd2_wr,
   output logic        odd3_wr,
   output logic        odd4_wr,
   output logic        even1_wr,
   output logic        even2_wr,
   output logic        even3_wr,
   output logic        even4_wr,
   output logic        oem_finish
);

   state_e           state, state_nx;
   logic [31:0]      sr;
   logic [4:0]       cnt;
   logic             msb_q;
   logic             end_q;
   logic [6:0]       pix_sh;
   logic [2:0]       bcnt;
   logic [8:0]       pcnt;
   logic             accept;
   logic             pix_done;
   logic [31:0]      frame_ld;
   logic [5:0]       nbits_ld;
   logic             wr_req;
   logic [7:0]       wr_data;
   logic             wr_busy;
   logic             wr_idle;
   logic [BANKS-1:0] odd_wr;
   logic [BANKS-1:0] even_wr;

   assign accept     = (state == S_IDLE) && load;
   assign pix_done   = (pcnt == 9'(NPIX));
   assign frame_ld   = build_frame(pi_data, pi_length, pi_fill, pi_low);
   assign nbits_ld   = frame_bits(pi_length);
   assign so_valid   = (state == S_SHIFT);
   assign so_data    = so_valid && (msb_q ? sr[31] : sr[0]);
   assign oem_finish = (state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      wr_req   = 1'b0;
      wr_data  = 8'h00;
      case (state)
         S_IDLE: begin
            if (load) state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            // Frames are whole bytes, so a pixel always completes on a frame's last bit.
            if (bcnt == 3'd7 && !pix_done) begin
               wr_req  = 1'b1;
               wr_data = {pix_sh, so_data};
            end
            if (cnt == 5'd0) state_nx = (end_q || pi_end) ? S_FILL : S_IDLE;
         end
         S_FILL: begin
            if (!pix_done && !wr_busy) wr_req = 1'b1;
            if (pix_done && wr_idle) state_nx = S_DONE;
         end
         default: state_nx = S_DONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr     <= '0;
         cnt    <= '0;
         msb_q  <= 1'b0;
         end_q  <= 1'b0;
         pix_sh <= '0;
         bcnt   <= '0;
         pcnt   <= '0;
      end else begin
         // MSB-first frames are left-aligned so bit 31 always carries the next bit.
         if (accept) begin
            sr    <= pi_msb ? (frame_ld << (6'd32 - nbits_ld)) : frame_ld;
            cnt   <= 5'(nbits_ld - 6'd1);
            msb_q <= pi_msb;
            end_q <= pi_end;
         end else if (state == S_SHIFT) begin
            sr  <= msb_q ? {sr[30:0], 1'b0} : {1'b0, sr[31:1]};
            cnt <= cnt - 5'd1;
         end
         if (state == S_SHIFT) begin
            pix_sh <= {pix_sh[5:0], so_data};
            bcnt   <= bcnt + 3'd1;
         end
         if (wr_req) pcnt <= pcnt + 9'd1;
      end
   end

   sti_dac_oem_wr u_oem_wr (
      .clk         (clk),
      .reset       (reset),
      .wr_req      (wr_req),
      .wr_pix      (pcnt[7:0]),
      .wr_data     (wr_data),
      .oem_addr    (oem_addr),
      .oem_dataout (oem_dataout),
      .odd_wr      (odd_wr),
      .even_wr     (even_wr),
      .busy        (wr_busy),
      .idle        (wr_idle)
   );

   assign {odd4_wr, odd3_wr, odd2_wr, odd1_wr}     = odd_wr;
   assign {even4_wr, even3_wr, even2_wr, even1_wr} = even_wr;

endmodule

// File: tb/tb_sti_dac_unit.sv
// tb/tb_sti_dac_unit.sv - randomized self-checking bench for sti_dac_unit
module tb_sti_dac_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        pi_fill, pi_msb, pi_low, pi_end;
   logic        so_data, so_valid;
   logic [4:0]  oem_addr;
   logic [7:0]  oem_dataout;
   logic        odd1_wr, odd2_wr, odd3_wr, odd4_wr;
   logic        even1_wr, even2_wr, even3_wr, even4_wr;
   logic        oem_finish;

   sti_dac_unit dut (
      .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
      .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
      .so_data(so_data), .so_valid(so_valid), .oem_addr(oem_addr), .oem_dataout(oem_dataout),
      .odd1_wr(odd1_wr), .odd2_wr(odd2_wr), .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
      .even1_wr(even1_wr), .even2_wr(even2_wr), .even3_wr(even3_wr), .even4_wr(even4_wr),
      .oem_finish(oem_finish)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         sel;
      logic [4:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   int   total = 0;
   int   bad = 0;
   logic model_bits[$];
   wr_t  wr_log[$];
   int   cyc = 0;
   int   multi_err = 0, stab_err = 0, fin_rises = 0, fin_nwr = -1, fin_cyc = -1;
   logic [4:0] prev_addr = '0;
   logic [7:0] prev_data = '0;
   logic       prev_fin = 1'b0;
   logic [7:0] strobes;

   assign strobes = {even4_wr, even3_wr, even2_wr, even1_wr, odd4_wr, odd3_wr, odd2_wr, odd1_wr};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory-side observer: records each strobe as a write into one of 8 memories.
   always @(negedge clk) begin
      int n, s;
      cyc++;
      n = 0; s = -1;
      for (int i = 0; i < 8; i++) if (strobes[i]) begin n++; s = i; end
      if (n > 1) multi_err++;
      if (n >= 1) begin
         if (oem_addr !== prev_addr || oem_dataout !== prev_data) stab_err++;
         wr_log.push_back('{sel: s, addr: oem_addr, data: oem_dataout, cyc: cyc});
      end
      if (oem_finish && !prev_fin) begin
         fin_rises++;
         fin_nwr = wr_log.size();
         fin_cyc = cyc;
      end
      prev_addr = oem_addr;
      prev_data = oem_dataout;
      prev_fin  = oem_finish;
   end

   function automatic logic [7:0] exp_pix(int k);
      logic [7:0] v;
      v = 8'h00;
      if (8 * k + 7 < model_bits.size())
         for (int b = 0; b < 8; b++) v = {v[6:0], model_bits[8 * k + b]};
      return v;
   endfunction

   // Image geometry: checkerboard (row+col even -> odd memory), 64 pixels per bank, 2 per address.
   task automatic check_writes(input int n);
      int r, c, e_sel;
      for (int k = 0; k < n && k < wr_log.size(); k++) begin
         r = k / 16; c = k % 16;
         e_sel = ((r + c) % 2 == 0) ? (k / 64) : 4 + (k / 64);
         check_eq($sformatf("wr%0d_sel", k), wr_log[k].sel, e_sel);
         check_eq($sformatf("wr%0d_addr", k), wr_log[k].addr, (k % 64) / 2);
         check_eq($sformatf("wr%0d_data", k), wr_log[k].data, exp_pix(k));
      end
   endtask

   task automatic send_word(input logic [1:0] len, input logic [15:0] data, input logic fill,
                            input logic msb, input logic low, input logic endf, input logic spur,
                            output logic [31:0] got);
      int n, gaps;
      logic [31:0] frame, seq;
      n = 8 * (int'(len) + 1);
      case (len)
         2'd0:    frame = low ? data / 256 : data % 256;
         2'd1:    frame = data;
         2'd2:    frame = fill ? data * 256 : data;
         default: frame = fill ? data * 65536 : data;
      endcase
      seq = 0;
      if (msb) seq = frame;
      else for (int i = 0; i < n; i++) seq[n - 1 - i] = frame[i];
      for (int i = n - 1; i >= 0; i--) model_bits.push_back(seq[i]);
      @(posedge clk); #1;
      load = 1'b1; pi_length = len; pi_data = data; pi_fill = fill;
      pi_msb = msb; pi_low = low; pi_end = endf;
      @(posedge clk); #1;
      load = 1'b0;
      got = 0; gaps = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!so_valid) gaps++;
         got = {got[30:0], so_data};
         if (spur) begin
            load = (i == n / 2);
            pi_data = ~data; pi_length = ~len; pi_msb = ~msb;
         end
      end
      load = 1'b0;
      @(negedge clk);
      check_eq("valid_end", so_valid, 1'b0);
      check_eq("valid_gap", gaps, 0);
      check_eq("frame", got, seq);
   endtask

   initial begin
      logic [31:0] got;
      logic [1:0]  lens[35];
      logic [1:0]  tmp;
      int          j;
      logic [7:0]  t4[4];
      int          cp[5][3];

      reset = 1'b0; load = 1'b0; pi_data = '0; pi_length = '0;
      pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_outs", {so_valid, so_data, strobes, oem_finish, oem_addr, oem_dataout}, 0);
      @(posedge clk); #1 reset = 1'b1;

      send_word(2'b00, 16'hA55A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, got);
      check_eq("t1_bits", got, 32'hA5);
      send_word(2'b01, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, got);
      check_eq("t2_bits", got, 32'h8000);
      send_word(2'b10, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, got);
      check_eq("t3_fill1", got, 32'hFFFF00);
      send_word(2'b10, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got);
      check_eq("t3_fill0", got, 32'h00FFFF);
      send_word(2'b11, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got);
      check_eq("t4_bits", got, 32'h00008000);
      repeat (4) @(negedge clk);
      check_eq("a_nwr", wr_log.size(), 13);
      check_writes(13);
      t4 = '{8'h00, 8'h00, 8'h80, 8'h00};
      for (int k = 0; k < 4; k++)
         if (wr_log.size() > 9 + k) check_eq($sformatf("t4_pix%0d", k), wr_log[9 + k].data, t4[k]);

      // Abort a frame mid-shift with reset.
      @(posedge clk); #1;
      load = 1'b1; pi_length = 2'b11; pi_data = 16'($urandom); pi_msb = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_eq("pre_rst_valid", so_valid, 1'b1);
      reset = 1'b0;
      #1 check_eq("rst_mid_valid", so_valid, 1'b0);
      @(negedge clk);
      check_eq("rst_mid_outs", {strobes, oem_finish, so_valid}, 0);
      @(posedge clk); #1 reset = 1'b1;
      wr_log.delete();
      model_bits.delete();

      // 35 words, 768 bits: 10x32b, 10x24b, 11x16b, 4x8b in random order.
      for (int k = 0; k < 35; k++)
         lens[k] = (k < 10) ? 2'd3 : (k < 20) ? 2'd2 : (k < 31) ? 2'd1 : 2'd0;
      for (int k = 34; k > 0; k--) begin
         j = $urandom_range(k, 0);
         tmp = lens[k]; lens[k] = lens[j]; lens[j] = tmp;
      end
      for (int k = 0; k < 35; k++)
         send_word(lens[k], 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   (k == 34), ($urandom_range(3, 0) == 0), got);
      check_eq("c_bits", model_bits.size(), 768);

      for (int i = 0; i < 3000 && !oem_finish; i++) @(negedge clk);
      check_eq("finish_seen", oem_finish, 1'b1);
      repeat (20) @(negedge clk);
      check_eq("finish_held", oem_finish, 1'b1);
      check_eq("fin_rises", fin_rises, 1);
      check_eq("fin_after_wr", fin_nwr, 256);
      check_eq("nwr", wr_log.size(), 256);
      if (wr_log.size() > 0) check_eq("fin_gap", fin_cyc - wr_log[wr_log.size() - 1].cyc, 2);
      check_eq("multi_strobe", multi_err, 0);
      check_eq("addr_stable", stab_err, 0);
      check_writes(256);

      cp = '{'{0, 0, 0}, '{1, 4, 0}, '{16, 4, 8}, '{17, 0, 8}, '{64, 1, 0}};
      for (int k = 0; k < 5; k++)
         if (wr_log.size() > cp[k][0]) begin
            check_eq($sformatf("cp_px%0d_mem", cp[k][0]), wr_log[cp[k][0]].sel, cp[k][1]);
            check_eq($sformatf("cp_px%0d_addr", cp[k][0]), wr_log[cp[k][0]].addr, cp[k][2]);
         end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
